// File: rtl/freq_counter_pkg.sv
// Shared definitions for the multi-channel reciprocal frequency counter:
// register map, control/status bit positions, channel FSM states.
package freq_counter_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_PERIODS = 8'h01;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h02;
  localparam logic [7:0] ADDR_STATUS  = 8'h03;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h04;
  localparam logic [7:0] ADDR_RESULT  = 8'h10;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_CONT      = 1;
  localparam int unsigned CTRL_SOFT_RST  = 2;
  localparam int unsigned CTRL_CH_EN_LSB = 8;

  localparam int unsigned STAT_DONE_LSB = 0;
  localparam int unsigned STAT_TOUT_LSB = 8;
  localparam int unsigned STAT_BUSY_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] data;
  } wb_req_t;

  // Control registers at 0x00..0x04, one RESULT word per channel from 0x10.
  function automatic logic addr_mapped(input logic [7:0] a, input int unsigned n_ch);
    return (a <= ADDR_IRQ_EN) || ((a[7:4] == 4'h1) && (32'(a[3:0]) < n_ch));
  endfunction

endpackage

// File: rtl/freq_chan.sv
// One measurement channel: input synchroniser, rising-edge detector,
// IDLE/ARM/MEAS sequencer, cycle and period counters, result register.
module freq_chan
  import freq_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PER_W = 16
) (
  input  logic             clk_i,
  input  logic             ext_rst_i,
  input  logic             soft_rst,
  input  logic             start,
  input  logic             en,
  input  logic             cont,
  input  logic [PER_W-1:0] periods,
  input  logic [CNT_W-1:0] timeout,
  input  logic             signal_in,
  output logic             busy,
  output logic             done_set_c,
  output logic             tout_set_c,
  output logic [CNT_W-1:0] result
);

  logic [2:0]       sync_q;
  logic             edge_q;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc_c;
  logic [PER_W-1:0] per_q, per_d, per_inc_c, periods_eff_c;
  logic [CNT_W-1:0] result_d;
  logic             tout_hit_c;

  // sync_q[2] doubles as the delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], signal_in};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign periods_eff_c = (periods == '0) ? PER_W'(1) : periods;
  assign cyc_inc_c     = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
  assign per_inc_c     = per_q + PER_W'(1);
  assign tout_hit_c    = (timeout != '0) && (cyc_q == timeout);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    per_d      = per_q;
    result_d   = result;
    done_set_c = 1'b0;
    tout_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && en) begin
          state_d = ST_ARM;
          cyc_d   = CNT_W'(1);
          per_d   = '0;
        end
      end
      ST_ARM: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (edge_q) begin
          state_d = ST_MEAS;
          cyc_d   = CNT_W'(1);
          per_d   = '0;
        end else if (tout_hit_c) begin
          state_d    = ST_IDLE;
          tout_set_c = 1'b1;
        end else begin
          cyc_d = cyc_inc_c;
        end
      end
      ST_MEAS: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_inc_c;
          if (edge_q) begin
            per_d = per_inc_c;
            if (per_inc_c == periods_eff_c) begin
              result_d   = cyc_q;
              done_set_c = 1'b1;
              // the closing edge opens the next window in continuous mode
              if (cont) begin
                cyc_d = CNT_W'(1);
                per_d = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
          if (!done_set_c && tout_hit_c) begin
            state_d    = ST_IDLE;
            tout_set_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!ext_rst_i || soft_rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      per_q   <= '0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      per_q   <= per_d;
      result  <= result_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel reciprocal frequency counter with a Wishbone slave port;
// holds the register file, sticky status with W1C, and the interrupt.
module freq_counter_mc
  import freq_counter_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PER_W = 16
) (
  input  logic            clk_i,
  input  logic            ext_rst_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     dat_i,
  input  logic            we_i,
  input  logic [3:0]      sel_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic [N_CH-1:0] signal_in,
  output logic [31:0]     dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            rty_o,
  output logic            irq_o
);

  wb_req_t          req;
  logic             req_valid_c, mapped_c, wr_status_c;
  logic [31:0]      rd_data_c;
  logic             cont_q, start_q, soft_q;
  logic [N_CH-1:0]  ch_en_q, irq_en_done_q, irq_en_tout_q;
  logic [N_CH-1:0]  done_q, tout_q, done_d, tout_d, done_clr_c, tout_clr_c;
  logic [PER_W-1:0] periods_q;
  logic [CNT_W-1:0] timeout_q;
  logic [N_CH-1:0]  busy_w, done_set_c, tout_set_c;
  logic [N_CH-1:0][CNT_W-1:0] result_w;
  logic             unused_bits;

  assign req         = '{addr: addr_i[7:0], we: we_i, data: dat_i};
  assign req_valid_c = cyc_i & stb_i & ~(ack_o | err_o);
  assign mapped_c    = addr_mapped(req.addr, N_CH);
  assign rty_o       = 1'b0;
  assign unused_bits = ^{addr_i[31:8], sel_i, dat_i};

  always_comb begin
    rd_data_c = '0;
    case (req.addr)
      ADDR_CTRL: begin
        rd_data_c[CTRL_CONT]                = cont_q;
        rd_data_c[CTRL_CH_EN_LSB +: N_CH]   = ch_en_q;
      end
      ADDR_PERIODS: rd_data_c = 32'(periods_q);
      ADDR_TIMEOUT: rd_data_c = 32'(timeout_q);
      ADDR_STATUS: begin
        rd_data_c[STAT_DONE_LSB +: N_CH] = done_q;
        rd_data_c[STAT_TOUT_LSB +: N_CH] = tout_q;
        rd_data_c[STAT_BUSY_LSB +: N_CH] = busy_w;
      end
      ADDR_IRQ_EN: begin
        rd_data_c[STAT_DONE_LSB +: N_CH] = irq_en_done_q;
        rd_data_c[STAT_TOUT_LSB +: N_CH] = irq_en_tout_q;
      end
      default: begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
          if (req.addr == ADDR_RESULT + 8'(ch)) rd_data_c = 32'(result_w[ch]);
        end
      end
    endcase
  end

  // hardware set takes priority over a same-cycle software clear
  assign wr_status_c = req_valid_c & req.we & (req.addr == ADDR_STATUS);
  assign done_clr_c  = wr_status_c ? req.data[STAT_DONE_LSB +: N_CH] : '0;
  assign tout_clr_c  = wr_status_c ? req.data[STAT_TOUT_LSB +: N_CH] : '0;
  assign done_d      = (done_q & ~done_clr_c) | done_set_c;
  assign tout_d      = (tout_q & ~tout_clr_c) | tout_set_c;

  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      dat_o         <= '0;
      ack_o         <= 1'b0;
      err_o         <= 1'b0;
      irq_o         <= 1'b0;
      cont_q        <= 1'b0;
      start_q       <= 1'b0;
      soft_q        <= 1'b0;
      ch_en_q       <= '0;
      periods_q     <= PER_W'(1);
      timeout_q     <= '0;
      irq_en_done_q <= '0;
      irq_en_tout_q <= '0;
      done_q        <= '0;
      tout_q        <= '0;
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
      start_q <= 1'b0;
      soft_q  <= 1'b0;
      if (req_valid_c) begin
        ack_o <= mapped_c;
        err_o <= !mapped_c;
        if (!req.we) begin
          dat_o <= rd_data_c;
        end else begin
          case (req.addr)
            ADDR_CTRL: begin
              start_q <= req.data[CTRL_START];
              cont_q  <= req.data[CTRL_CONT];
              soft_q  <= req.data[CTRL_SOFT_RST];
              ch_en_q <= req.data[CTRL_CH_EN_LSB +: N_CH];
            end
            ADDR_PERIODS: periods_q <= PER_W'(req.data);
            ADDR_TIMEOUT: timeout_q <= CNT_W'(req.data);
            ADDR_IRQ_EN: begin
              irq_en_done_q <= req.data[STAT_DONE_LSB +: N_CH];
              irq_en_tout_q <= req.data[STAT_TOUT_LSB +: N_CH];
            end
            default: ;
          endcase
        end
      end
      if (soft_q) begin
        done_q <= '0;
        tout_q <= '0;
      end else begin
        done_q <= done_d;
        tout_q <= tout_d;
      end
      irq_o <= |((done_q & irq_en_done_q) | (tout_q & irq_en_tout_q));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    freq_chan #(
      .CNT_W(CNT_W),
      .PER_W(PER_W)
    ) u_chan (
      .clk_i      (clk_i),
      .ext_rst_i  (ext_rst_i),
      .soft_rst   (soft_q),
      .start      (start_q),
      .en         (ch_en_q[g]),
      .cont       (cont_q),
      .periods    (periods_q),
      .timeout    (timeout_q),
      .signal_in  (signal_in[g]),
      .busy       (busy_w[g]),
      .done_set_c (done_set_c[g]),
      .tout_set_c (tout_set_c[g]),
      .result     (result_w[g])
    );
  end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Directed self-checking bench for freq_counter_mc.
module tb_freq_counter_mc;

  localparam int unsigned N_CH = 4;

  logic            clk_i = 1'b0;
  logic            ext_rst_i;
  logic [31:0]     addr_i, dat_i;
  logic            we_i;
  logic [3:0]      sel_i;
  logic            cyc_i, stb_i;
  logic [N_CH-1:0] signal_in;
  logic [31:0]     dat_o;
  logic            ack_o, err_o, rty_o, irq_o;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int last_ack_cyc = 0;
  int sig_per [N_CH] = '{default: 0};
  bit irq_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  freq_counter_mc #(.N_CH(N_CH), .CNT_W(32), .PER_W(16)) dut (
    .clk_i     (clk_i),
    .ext_rst_i (ext_rst_i),
    .addr_i    (addr_i),
    .dat_i     (dat_i),
    .we_i      (we_i),
    .sel_i     (sel_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .signal_in (signal_in),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .rty_o     (rty_o),
    .irq_o     (irq_o)
  );

  // clock-aligned square waves, period sig_per[ch] cycles, 0 = held low
  initial begin
    int cnt [N_CH];
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = 0;
    signal_in = '0;
    forever begin
      @(posedge clk_i);
      #2;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (sig_per[ch] == 0) begin
          cnt[ch] = 0;
          signal_in[ch] = 1'b0;
        end else begin
          cnt[ch] = (cnt[ch] + 1) % sig_per[ch];
          signal_in[ch] = (cnt[ch] < sig_per[ch] / 2);
        end
      end
    end
  end

  // cycle counter and irq rising-edge timestamps
  initial begin
    forever begin
      @(posedge clk_i);
      cycle++;
      @(negedge clk_i);
      if (irq_o && !irq_prev) begin
        rise_cnt++;
        rise_cyc = cycle;
      end
      irq_prev = irq_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  task automatic wb_xfer(input logic [7:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] rd, output logic ak, output logic er);
    addr_i = {24'h0, a};
    dat_i  = d;
    we_i   = we;
    sel_i  = 4'hF;
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    ak = 1'b0; er = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (ack_o || err_o) begin
        ak = ack_o; er = err_o; rd = dat_o;
        last_ack_cyc = cycle;
        break;
      end
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    checks++;
    if (!(ak || er)) begin
      failures++;
      $display("FAIL bus_response addr=%02h got=none exp=ack_or_err", a);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    logic ak, unused_er;
    wb_xfer(a, 1'b1, d, unused_rd, ak, unused_er);
    checks++;
    if (ak !== 1'b1) begin
      failures++;
      $display("FAIL write_ack addr=%02h got=%b exp=1", a, ak);
    end
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    logic ak, unused_er;
    wb_xfer(a, 1'b0, 32'h0, d, ak, unused_er);
    checks++;
    if (ak !== 1'b1) begin
      failures++;
      $display("FAIL read_ack addr=%02h got=%b exp=1", a, ak);
    end
  endtask

  task automatic poll_status(input logic [31:0] mask, input int budget, output logic [31:0] st);
    int t0;
    t0 = cycle;
    st = '0;
    while (((st & mask) != mask) && (cycle - t0 < budget)) wb_read(8'h03, st);
  endtask

  task automatic wait_rise(input int prev, input int budget, output bit ok);
    int t0;
    t0 = cycle;
    while ((rise_cnt == prev) && (cycle - t0 < budget)) begin
      @(posedge clk_i);
      #1;
    end
    ok = (rise_cnt != prev);
  endtask

  task automatic wait_until(input int target);
    while (cycle < target) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    ext_rst_i = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    addr_i = '0; dat_i = '0; sel_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    ext_rst_i = 1'b1;
    checks++;
    if ({ack_o, err_o, rty_o, irq_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {ack_o, err_o, rty_o, irq_o});
    end
    checks++;
    if (dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_dat got=%h exp=0", dat_o);
    end
    wb_read(8'h01, rd);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL reset_periods got=%h exp=1", rd); end
    wb_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    wb_read(8'h03, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", rd); end
    wb_read(8'h02, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_timeout got=%h exp=0", rd); end
  endtask

  task automatic test_single;
    logic [31:0] st, rd;
    sig_per[0] = 40;
    wb_write(8'h01, 32'd10);
    wb_write(8'h04, 32'h1);
    wb_write(8'h00, 32'h101);
    poll_status(32'h1, 2000, st);
    checks++;
    if (st[0] !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", st[0]); end
    checks++;
    if (st[16] !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", st[16]); end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd400) begin failures++; $display("FAIL single_result got=%0d exp=400", rd); end
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL single_irq got=%b exp=1", irq_o); end
  endtask

  task automatic test_cont;
    logic [31:0] st, rd;
    int p, r1;
    bit ok;
    wb_write(8'h03, 32'hFFFF);
    sig_per[0] = 25;
    wb_write(8'h01, 32'd4);
    p = rise_cnt;
    wb_write(8'h00, 32'h103);
    wait_rise(p, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL cont_first_done got=none exp=irq_rise"); end
    r1 = rise_cyc;
    wb_write(8'h03, 32'h1);
    for (int k = 0; k < 2; k++) begin
      p = rise_cnt;
      wait_rise(p, 300, ok);
      checks++;
      if (!ok || (rise_cyc - r1) != 100) begin
        failures++;
        $display("FAIL cont_spacing window=%0d got=%0d exp=100", k, rise_cyc - r1);
      end
      r1 = rise_cyc;
      wb_read(8'h10, rd);
      checks++;
      if (rd !== 32'd100) begin failures++; $display("FAIL cont_result got=%0d exp=100", rd); end
      wb_write(8'h03, 32'h1);
    end
    wb_write(8'h00, 32'h0);
    wb_read(8'h03, st);
    checks++;
    if (st[16] !== 1'b0) begin failures++; $display("FAIL cont_abort_busy got=%b exp=0", st[16]); end
    wb_write(8'h03, 32'hFFFF);
  endtask

  task automatic test_timeout;
    logic [31:0] st, rd;
    int p;
    bit ok;
    sig_per[0] = 0;
    wb_write(8'h04, 32'h100);
    wb_write(8'h03, 32'hFFFF);
    wb_write(8'h02, 32'd1000);
    p = rise_cnt;
    wb_write(8'h00, 32'h101);
    wait_rise(p, 1200, ok);
    checks++;
    if (!ok || (rise_cyc - last_ack_cyc) != 1002) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=1002", rise_cyc - last_ack_cyc);
    end
    wb_read(8'h03, st);
    checks++;
    if (st[23:0] !== 24'h000100) begin failures++; $display("FAIL timeout_status got=%h exp=000100", st[23:0]); end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd100) begin failures++; $display("FAIL timeout_result got=%0d exp=100", rd); end
    wb_write(8'h02, 32'd0);
    wb_write(8'h03, 32'hFFFF);
  endtask

  task automatic test_multi;
    logic [31:0] st, rd;
    int exp_res [N_CH] = '{80, 160, 240, 320};
    sig_per[0] = 10; sig_per[1] = 20; sig_per[2] = 30; sig_per[3] = 40;
    wb_write(8'h04, 32'h0);
    wb_write(8'h03, 32'hFFFF);
    wb_write(8'h01, 32'd8);
    wb_write(8'h00, 32'h0F01);
    poll_status(32'hF, 2000, st);
    checks++;
    if (st[23:0] !== 24'h00000F) begin failures++; $display("FAIL multi_status got=%h exp=00000f", st[23:0]); end
    for (int i = 0; i < N_CH; i++) begin
      wb_read(8'(16 + i), rd);
      checks++;
      if (rd !== 32'(exp_res[i])) begin
        failures++;
        $display("FAIL multi_result ch=%0d got=%0d exp=%0d", i, rd, exp_res[i]);
      end
    end
    wb_write(8'h03, 32'h5);
    wb_read(8'h03, st);
    checks++;
    if (st[7:0] !== 8'h0A) begin failures++; $display("FAIL multi_w1c got=%h exp=0a", st[7:0]); end
  endtask

  task automatic test_soft_reset;
    logic [31:0] rd;
    wb_write(8'h00, 32'h0F04);
    wb_read(8'h03, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL soft_status got=%h exp=0", rd); end
    wb_read(8'h13, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL soft_result got=%h exp=0", rd); end
    wb_read(8'h01, rd);
    checks++;
    if (rd !== 32'd8) begin failures++; $display("FAIL soft_periods got=%h exp=8", rd); end
    wb_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0F00) begin failures++; $display("FAIL soft_ctrl got=%h exp=0f00", rd); end
  endtask

  task automatic test_err;
    logic [31:0] rd;
    logic ak, er;
    wb_xfer(8'h07, 1'b0, 32'h0, rd, ak, er);
    checks++;
    if ({ak, er} !== 2'b01) begin failures++; $display("FAIL err_0x07 got=ack%b_err%b exp=ack0_err1", ak, er); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL err_data got=%h exp=0", rd); end
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL err_width got=%b exp=0", err_o); end
    wb_xfer(8'h14, 1'b0, 32'h0, rd, ak, er);
    checks++;
    if ({ak, er} !== 2'b01) begin failures++; $display("FAIL err_0x14 got=ack%b_err%b exp=ack0_err1", ak, er); end
  endtask

  task automatic test_set_wins;
    logic [31:0] st;
    int p, r;
    bit ok;
    sig_per[0] = 25;
    wb_write(8'h03, 32'hFFFF);
    wb_write(8'h01, 32'd4);
    wb_write(8'h04, 32'h1);
    p = rise_cnt;
    wb_write(8'h00, 32'h103);
    wait_rise(p, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL setwins_first got=none exp=irq_rise"); end
    r = rise_cyc;
    wb_write(8'h03, 32'h1);
    wb_read(8'h03, st);
    checks++;
    if (st[0] !== 1'b0) begin failures++; $display("FAIL setwins_clear got=%b exp=0", st[0]); end
    // next done lands on edge r+99; the W1C is sampled on that same edge
    wait_until(r + 98);
    wb_write(8'h03, 32'h1);
    wb_read(8'h03, st);
    checks++;
    if (st[0] !== 1'b1) begin failures++; $display("FAIL setwins_collide got=%b exp=1", st[0]); end
  endtask

  task automatic test_ext_reset;
    logic [31:0] st, rd;
    wb_read(8'h03, st);
    checks++;
    if (st[16] !== 1'b1) begin failures++; $display("FAIL extrst_pre_busy got=%b exp=1", st[16]); end
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL extrst_pre_irq got=%b exp=1", irq_o); end
    ext_rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    ext_rst_i = 1'b1;
    checks++;
    if ({ack_o, err_o, rty_o, irq_o} !== 4'b0000 || dat_o !== 32'h0) begin
      failures++;
      $display("FAIL extrst_outputs got=%b_%h exp=0000_0", {ack_o, err_o, rty_o, irq_o}, dat_o);
    end
    wb_read(8'h01, rd);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL extrst_periods got=%h exp=1", rd); end
    wb_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL extrst_ctrl got=%h exp=0", rd); end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL extrst_result got=%h exp=0", rd); end
    repeat (200) @(posedge clk_i);
    #1;
    wb_read(8'h03, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL extrst_status got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_timeout();
    test_multi();
    test_soft_reset();
    test_err();
    test_set_wins();
    test_ext_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_counter_mc.md
# freq_counter_mc

Multi-channel reciprocal frequency counter, next generation of the single-channel counter. Per channel, it measures the number of `clk_i` cycles spanning a programmable number of input-signal periods. Each channel has its own timeout, one-shot or continuous mode, and a sticky done/timeout status. The block sits on the Wishbone bus as a slave next to the existing peripherals. Everything runs in the `clk_i` domain; input signals are synchronised internally.

## Interface
- `N_CH`, default 4: number of measured channels, 1..8.
- `CNT_W`, default 32: cycle-count result width.
- `PER_W`, default 16: width of the period-count setting.
- `clk_i` in 1: system/reference clock. One clock; all logic on its rising edge.
- `ext_rst_i` in 1: reset, synchronous, active-low.
- `addr_i` in 32: word address; only `addr_i[7:0]` is decoded.
- `dat_i` in 32: write data.
- `we_i` in 1: write enable.
- `sel_i` in 4: byte selects; ignored, full-word access only.
- `cyc_i`, `stb_i` in 1: Wishbone cycle and strobe.
- `signal_in` in N_CH: asynchronous target signals, one bit per channel.
- `dat_o` out 32: read data.
- `ack_o` out 1: transfer acknowledge.
- `err_o` out 1: unmapped-address acknowledge.
- `rty_o` out 1: tied 0.
- `irq_o` out 1: OR of (STATUS.done | STATUS.timeout) & IRQ_EN.

## Operation
- Register map (word addresses):
  - 0x00 CTRL: bit0 START, self-clearing. bit1 CONT. bit2 SOFT_RST, self-clearing. bits[15:8] CH_EN mask.
  - 0x01 PERIODS[PER_W-1:0]: input periods per measurement. 0 is treated as 1.
  - 0x02 TIMEOUT[CNT_W-1:0]: cycle limit per measurement. 0 disables the timeout.
  - 0x03 STATUS: bits[7:0] done, bits[15:8] timeout, bits[23:16] busy. Done and timeout bits are write-1-to-clear; busy is read-only.
  - 0x04 IRQ_EN: bits[15:0], same bit layout as STATUS[15:0].
  - 0x10+ch RESULT[ch]: last completed cycle count for channel ch, read-only.
  - Any other address: `err_o` instead of `ack_o`. Writes to it have no effect; reads return 0.
- Per-channel input path:
  - 2-FF synchroniser, then a registered rising-edge detector producing the `edge` pulse.
  - Same latency on every edge, so the latency cancels in the measurement.
- Per-channel FSM:
  - IDLE: on START with CH_EN[ch]=1, go to ARM; busy=1.
  - ARM: wait for `edge`. On `edge`: cyc_cnt←1, per_cnt←0, go to MEAS.
  - MEAS: every cycle cyc_cnt+1. On `edge`: per_cnt+1.
    - When per_cnt reaches PERIODS on an edge: RESULT←cyc_cnt, done←1.
    - Then if CONT=1: restart in place with cyc_cnt←1, per_cnt←0, staying in MEAS. That edge starts the next window, so there is no dead time.
    - Otherwise go to IDLE; busy=0.
  - Timeout: cyc_cnt is also counted during ARM. When cyc_cnt equals TIMEOUT (nonzero) in ARM or MEAS: timeout←1, RESULT unchanged, go to IDLE.
  - Clearing CH_EN[ch] while busy aborts the channel to IDLE. No flags are set.
- START while a channel is busy is ignored for that channel.
- SOFT_RST or `ext_rst_i`=0 returns all channels to IDLE and clears STATUS and RESULT. SOFT_RST leaves CTRL config and PERIODS/TIMEOUT intact; `ext_rst_i` clears them too.
- Simultaneous events:
  - A hardware done/timeout set and a software W1C of the same bit in the same cycle: set wins.
  - Done and timeout in the same cycle: done wins.

## Timing
- Reset values: `dat_o`=0, `ack_o`=0, `err_o`=0, `rty_o`=0, `irq_o`=0; all registers 0; PERIODS=1.
- Bus handshake:
  - `ack_o`/`err_o` is registered and asserted the cycle after `cyc_i & stb_i` is sampled with `ack_o|err_o`=0.
  - It is held high for exactly 1 cycle.
  - Read data is valid in `dat_o` in the same cycle as `ack_o`.
  - Writes take effect on the ack cycle.
- START to ARM: 1 cycle after the write ack.
- Input edge to the FSM seeing `edge`: 3 `clk_i` cycles.
- Done flag and RESULT update in the same cycle. `irq_o` follows 1 cycle later.
- The input signal must be below clk_i/2 with both phases at least 2 cycles wide. Above that, edges are lost with no detection.
- cyc_cnt saturates at 2^CNT_W−1 and never wraps.

## Structure
- Package `freq_counter_pkg`: register address constants, CTRL/STATUS bit indices, channel FSM state enum (IDLE, ARM, MEAS).
- Sub-module `freq_chan`: synchroniser, edge detector, FSM, cyc_cnt/per_cnt and RESULT for one channel. Instantiated N_CH times by a generate loop.
- The top level holds the Wishbone decode, CTRL/PERIODS/TIMEOUT/IRQ_EN registers, STATUS W1C logic and the `irq_o` reduction.

## Test plan
- Channel 0, period 40 cycles, PERIODS=10, START → done[0]=1, RESULT[0]=400, busy[0]=0.
- CONT=1, period 25 cycles, PERIODS=4 → RESULT[0]=100 on every window, with successive done sets exactly 100 cycles apart.
- Static input, TIMEOUT=1000, START → timeout[0]=1 at cycle 1000 after ARM; RESULT[0] keeps its old value; busy drops.
- Four channels with periods 10/20/30/40 cycles, PERIODS=8, CH_EN=0x0F → RESULT = 80/160/240/320; STATUS done=0x0F; write 0x05 to STATUS → done=0x0A.
- `ext_rst_i`=0 for 1 cycle mid-MEAS → all outputs and registers at reset values next cycle. Read of 0x07 → `err_o` pulse for 1 cycle, `dat_o`=0.
- A done set and a W1C of the same bit in the same cycle → the bit reads 1 afterwards.
